// File: rtl/ext_col_packer.sv
// Streaming column extractor: picks a byte range out of every row of a frame and
// packs the selected bytes contiguously into wide output words with end-of-frame flush.
//
// state  | meaning
// S_IDLE | waiting for i_start, no beats accepted
// S_RUN  | extracting row beats into the accumulator, emitting full words
// S_FLUSH| input closed; drain full words, then the final (possibly partial) word
module ext_col_packer #(
  parameter int BUS_BYTES = 16,
  parameter int OUT_BEATS = 2,
  parameter int RSZ_W     = 5,
  parameter int OFF_W     = 9
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_start,
  input  logic [RSZ_W-1:0]                      i_r_size,
  input  logic [OFF_W-1:0]                      i_col_start,
  input  logic [OFF_W-1:0]                      i_col_width,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [8*BUS_BYTES-1:0]                i_data,
  input  logic                                  i_last,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [8*OUT_BEATS*BUS_BYTES-1:0]      o_data,
  output logic [$clog2(OUT_BEATS*BUS_BYTES):0]  o_keep,
  output logic                                  o_last,
  output logic                                  o_cfg_err,
  output logic                                  o_busy
);

  localparam int OUT_BYTES = OUT_BEATS * BUS_BYTES;
  localparam int ACC_BYTES = OUT_BYTES + BUS_BYTES - 1;
  localparam int FILL_W    = $clog2(ACC_BYTES + 1);
  localparam int KEEP_W    = $clog2(OUT_BYTES) + 1;
  localparam int LOG_B     = $clog2(BUS_BYTES);
  localparam int CNT_W     = LOG_B + 1;
  localparam int POS_W     = (((RSZ_W + LOG_B) > OFF_W) ? (RSZ_W + LOG_B) : OFF_W) + 1;

  localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_BYTES);
  localparam logic [POS_W-1:0]  BUS_POS  = POS_W'(BUS_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [8*ACC_BYTES-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [RSZ_W-1:0]         beat_q, beat_d;
  logic [RSZ_W-1:0]         rsz_q, rsz_d;
  logic [OFF_W-1:0]         cs_q, cs_d;
  logic [OFF_W-1:0]         cw_q, cw_d;
  logic                     err_q, err_d;

  logic [RSZ_W-1:0]         r_eff, r_eff_in;
  logic [POS_W-1:0]         base, beat_end, col_lo, col_hi;
  logic [POS_W-1:0]         sel_lo_pos, sel_hi_pos;
  logic [POS_W-1:0]         span_in, end_in;
  logic [CNT_W-1:0]         sel_cnt;
  logic [LOG_B-1:0]         sel_lane;
  logic [8*BUS_BYTES-1:0]   beat_mask, beat_sel;
  logic [8*ACC_BYTES-1:0]   acc_shift, acc_ins;
  logic [FILL_W-1:0]        fill_shift;
  logic                     in_fire, out_fire;

  // A row size of zero behaves as a one-beat row.
  assign r_eff    = (rsz_q == '0) ? RSZ_W'(1) : rsz_q;
  assign r_eff_in = (i_r_size == '0) ? RSZ_W'(1) : i_r_size;
  assign span_in  = POS_W'(r_eff_in) << LOG_B;
  assign end_in   = POS_W'(i_col_start) + POS_W'(i_col_width);

  assign o_busy    = (state_q != S_IDLE);
  assign o_valid   = (state_q == S_FLUSH) || ((state_q == S_RUN) && (fill_q >= OUT_FILL));
  assign o_last    = (state_q == S_FLUSH) && (fill_q <= OUT_FILL);
  assign o_ready   = (state_q == S_RUN) && ((fill_q < OUT_FILL) || i_ready);
  assign o_keep    = !o_valid ? '0 :
                     ((fill_q >= OUT_FILL) ? KEEP_W'(OUT_BYTES) : KEEP_W'(fill_q));
  assign o_data    = o_valid ? acc_q[8*OUT_BYTES-1:0] : '0;
  assign o_cfg_err = err_q;

  assign out_fire  = o_valid && i_ready;
  assign in_fire   = i_valid && o_ready;

  // The selected range is contiguous, so each beat contributes one lane run.
  always_comb begin
    base       = POS_W'(beat_q) << LOG_B;
    beat_end   = base + BUS_POS;
    col_lo     = POS_W'(cs_q);
    col_hi     = POS_W'(cs_q) + POS_W'(cw_q);
    sel_lo_pos = (col_lo > base) ? col_lo : base;
    sel_hi_pos = (col_hi < beat_end) ? col_hi : beat_end;
    sel_cnt    = '0;
    sel_lane   = '0;
    if (sel_hi_pos > sel_lo_pos) begin
      sel_cnt  = CNT_W'(sel_hi_pos - sel_lo_pos);
      sel_lane = LOG_B'(sel_lo_pos - base);
    end
    beat_mask = '0;
    for (int k = 0; k < BUS_BYTES; k++) begin
      beat_mask[8*k +: 8] = (CNT_W'(k) < sel_cnt) ? 8'hff : 8'h00;
    end
    beat_sel = (i_data >> {sel_lane, 3'b000}) & beat_mask;
  end

  // Drain happens before append so a same-cycle beat lands behind the remainder.
  always_comb begin
    fill_shift = out_fire ? (fill_q - OUT_FILL) : fill_q;
    acc_shift  = out_fire ? (acc_q >> (8*OUT_BYTES)) : acc_q;
    acc_ins    = (8*ACC_BYTES)'(beat_sel) << {fill_shift, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    beat_d  = beat_q;
    rsz_d   = rsz_q;
    cs_d    = cs_q;
    cw_d    = cw_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          rsz_d   = i_r_size;
          cs_d    = i_col_start;
          cw_d    = i_col_width;
          err_d   = (end_in > span_in);
          acc_d   = '0;
          fill_d  = '0;
          beat_d  = '0;
        end
      end
      S_RUN: begin
        acc_d  = acc_shift;
        fill_d = fill_shift;
        if (in_fire) begin
          acc_d  = acc_shift | acc_ins;
          fill_d = fill_shift + FILL_W'(sel_cnt);
          if (i_last) begin
            beat_d  = '0;
            state_d = S_FLUSH;
          end else if (beat_q == (r_eff - RSZ_W'(1))) begin
            beat_d = '0;
          end else begin
            beat_d = beat_q + RSZ_W'(1);
          end
        end
      end
      S_FLUSH: begin
        acc_d  = acc_shift;
        fill_d = fill_shift;
        if (out_fire && o_last) begin
          state_d = S_IDLE;
          acc_d   = '0;
          fill_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
      beat_q  <= '0;
      rsz_q   <= '0;
      cs_q    <= '0;
      cw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      beat_q  <= beat_d;
      rsz_q   <= rsz_d;
      cs_q    <= cs_d;
      cw_q    <= cw_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ext_col_packer.sv
// Directed bench for ext_col_packer: a byte-stream model builds the expected words,
// hand-computed constants pin down the key scenarios.
module tb_ext_col_packer;
  localparam int OB = 32;

  logic         i_clk = 1'b0;
  logic         i_rst, i_start;
  logic [4:0]   i_r_size;
  logic [8:0]   i_col_start, i_col_width;
  logic         i_valid, o_ready;
  logic [127:0] i_data;
  logic         i_last, o_valid, i_ready;
  logic [255:0] o_data;
  logic [5:0]   o_keep;
  logic         o_last, o_cfg_err, o_busy;

  localparam logic [127:0] D1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] D2 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [255:0] S1_W0 =
    256'h4433221100_887766554433221100_887766554433221100_887766554433221100;
  localparam logic [255:0] S1_W1 = 256'h88776655;
  localparam logic [255:0] S2_W  = {4{64'h33221100ffeeddcc}};

  ext_col_packer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_r_size(i_r_size),
    .i_col_start(i_col_start), .i_col_width(i_col_width), .i_valid(i_valid),
    .o_ready(o_ready), .i_data(i_data), .i_last(i_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_keep(o_keep), .o_last(o_last),
    .o_cfg_err(o_cfg_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass = 0;
  int cfg_rsz, cfg_cs, cfg_cw, bidx, stall_cycles;
  logic [7:0]   exp_bytes[$];
  logic [255:0] got_data[$];
  logic [5:0]   got_keep[$];
  logic         got_last[$];

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      got_data.push_back(o_data);
      got_keep.push_back(o_keep);
      got_last.push_back(o_last);
    end
  end

  task automatic start_frame(input int rsz, input int cs, input int cw);
    cfg_rsz = rsz; cfg_cs = cs; cfg_cw = cw; bidx = 0;
    exp_bytes.delete(); got_data.delete(); got_keep.delete(); got_last.delete();
    i_r_size = 5'(rsz); i_col_start = 9'(cs); i_col_width = 9'(cw);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input logic last);
    int t = 0;
    int r, pos;
    i_valid = 1'b1; i_data = d; i_last = last;
    @(negedge i_clk);
    while (!o_ready && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    stall_cycles += t;
    if (!o_ready) chk("beat_accept_timeout", 256'(o_ready), 256'(1));
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
    r = (cfg_rsz == 0) ? 1 : cfg_rsz;
    for (int k = 0; k < 16; k++) begin
      pos = bidx * 16 + k;
      if (pos >= cfg_cs && pos < cfg_cs + cfg_cw) exp_bytes.push_back(d[8*k +: 8]);
    end
    bidx = last ? 0 : (bidx + 1) % r;
  endtask

  task automatic check_frame(input string tag);
    int t = 0;
    int nb, nw, kw, idx;
    logic [255:0] w;
    while (!(got_last.size() > 0 && got_last[got_last.size()-1]) && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    chk({tag, "_done"}, 256'(got_last.size() > 0 && got_last[got_last.size()-1]), 256'(1));
    nb = exp_bytes.size();
    nw = (nb == 0) ? 1 : (nb + OB - 1) / OB;
    chk({tag, "_nwords"}, 256'(got_data.size()), 256'(nw));
    for (int wi = 0; wi < nw && wi < got_data.size(); wi++) begin
      w = '0;
      for (int j = 0; j < OB; j++) begin
        idx = wi * OB + j;
        if (idx < nb) w[8*j +: 8] = exp_bytes[idx];
      end
      kw = (wi == nw - 1) ? nb - wi * OB : OB;
      chk($sformatf("%s_w%0d_data", tag, wi), got_data[wi], w);
      chk($sformatf("%s_w%0d_keep", tag, wi), 256'(got_keep[wi]), 256'(kw));
      chk($sformatf("%s_w%0d_last", tag, wi), 256'(got_last[wi]), 256'(wi == nw - 1));
    end
    @(posedge i_clk); #1;
    chk({tag, "_idle"}, 256'(o_busy), 256'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    i_data = '0; i_r_size = '0; i_col_start = '0; i_col_width = '0;
    stall_cycles = 0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 256'(o_valid), 256'(0));
    chk("rst_ready", 256'(o_ready), 256'(0));
    chk("rst_busy", 256'(o_busy), 256'(0));
    chk("rst_err", 256'(o_cfg_err), 256'(0));
    chk("rst_keep", 256'(o_keep), 256'(0));
    chk("rst_data", o_data, 256'(0));
    i_rst = 1'b0;
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    chk("idle_ready", 256'(o_ready), 256'(0));
    i_valid = 1'b0;

    // 9-byte column, 4 one-beat rows
    start_frame(1, 0, 9);
    chk("s1_err", 256'(o_cfg_err), 256'(0));
    chk("s1_busy", 256'(o_busy), 256'(1));
    for (int i = 0; i < 4; i++) send_beat(D1, i == 3);
    check_frame("s1");
    chk("s1_hand_w0", got_data[0], S1_W0);
    chk("s1_hand_w1", got_data[1], S1_W1);
    chk("s1_hand_k1", 256'(got_keep[1]), 256'(4));

    // column spanning a beat boundary, exactly one full word
    start_frame(2, 12, 8);
    chk("s2_err", 256'(o_cfg_err), 256'(0));
    for (int i = 0; i < 8; i++) send_beat(D1, i == 7);
    check_frame("s2");
    chk("s2_hand_w0", got_data[0], S2_W);

    // downstream stall with a pending beat
    i_ready = 1'b0;
    start_frame(1, 0, 9);
    for (int i = 0; i < 4; i++) send_beat(D1, 1'b0);
    i_valid = 1'b1; i_data = D1; i_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      chk($sformatf("s3_stall%0d_valid", c), 256'(o_valid), 256'(1));
      chk($sformatf("s3_stall%0d_ready", c), 256'(o_ready), 256'(0));
      chk($sformatf("s3_stall%0d_data", c), o_data, S1_W0);
      chk($sformatf("s3_stall%0d_keep", c), 256'(o_keep), 256'(32));
    end
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    send_beat(D1, 1'b1);
    check_frame("s3");
    chk("s3_hand_w0", got_data[0], S1_W0);

    // empty column
    start_frame(1, 0, 0);
    for (int i = 0; i < 3; i++) send_beat(D1, i == 2);
    check_frame("s4a");
    chk("s4a_hand_keep", 256'(got_keep[0]), 256'(0));
    chk("s4a_hand_data", got_data[0], 256'(0));

    // column running past the row end
    start_frame(1, 10, 10);
    chk("s4b_err", 256'(o_cfg_err), 256'(1));
    for (int i = 0; i < 3; i++) send_beat(D1, i == 2);
    check_frame("s4b");
    chk("s4b_hand_keep", 256'(got_keep[0]), 256'(18));
    chk("s4b_err_sticky", 256'(o_cfg_err), 256'(1));

    // reset mid-frame with 20 bytes buffered
    start_frame(1, 0, 10);
    chk("s5_err_clr", 256'(o_cfg_err), 256'(0));
    send_beat(D1, 1'b0);
    send_beat(D1, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    chk("s5_rst_valid", 256'(o_valid), 256'(0));
    chk("s5_rst_busy", 256'(o_busy), 256'(0));
    chk("s5_rst_keep", 256'(o_keep), 256'(0));
    chk("s5_rst_nwords", 256'(got_data.size()), 256'(0));
    start_frame(1, 0, 16);
    send_beat(D2, 1'b0);
    send_beat(D2, 1'b1);
    check_frame("s5");
    chk("s5_hand_w0", got_data[0], {D2, D2});

    // back-to-back full beats with continuous drain
    start_frame(1, 0, 16);
    stall_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'(i * 17 + 5);
      send_beat(D1 ^ {16{b}}, i == 5);
    end
    chk("s6_stalls", 256'(stall_cycles), 256'(0));
    check_frame("s6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ext_col_packer.md
Name: ext_col_packer

Overview:
- Streaming column extractor, successor to the single-column row extractor in the fetch unit.
- Input: rows arriving as R_SIZE beats of BUS_BYTES bytes each. For every row, selects the byte range [col_start, col_start+col_width), which may span beat boundaries.
- Packs the selected bytes contiguously into OUT_BEATS*BUS_BYTES-wide output words.
- Valid/ready on both sides, partial-word flush at end of frame. Sits between the row fetcher and the column write-back path.

Parameters:
- BUS_BYTES, 16, input beat width in bytes (power of 2).
- OUT_BEATS, 2, output word width in input beats; OUT_BYTES = OUT_BEATS*BUS_BYTES.
- RSZ_W, 5, width of row-size field in beats.
- OFF_W, 9, width of col_start/col_width byte fields.

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  pulse in IDLE: latch config, begin frame
- i_r_size  in  RSZ_W  beats per row (0 treated as 1)
- i_col_start  in  OFF_W  column byte offset within row
- i_col_width  in  OFF_W  column width in bytes
- i_valid  in  1  input beat valid
- o_ready  out  1  input beat accepted when i_valid&o_ready
- i_data  in  8*BUS_BYTES  row beat, byte lane k = bits [8k+7:8k]
- i_last  in  1  final beat of frame
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accept
- o_data  out  8*OUT_BYTES  packed column bytes, first byte in lane 0
- o_keep  out  clog2(OUT_BYTES)+1  number of valid bytes in o_data
- o_last  out  1  final word of frame
- o_cfg_err  out  1  sticky: col_start+col_width > r_size*BUS_BYTES at latch
- o_busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, i_rst=1 at an edge):
  - State to IDLE; fill counter, beat counter and accumulator to 0.
  - o_valid, o_last, o_cfg_err, o_busy, o_keep, o_data to 0; o_ready 0.
  - Reset mid-frame drops all buffered bytes and emits nothing.
- IDLE:
  - o_ready=0. i_start latches all config and clears o_cfg_err; the error flag is set that same edge if the config check fails. Next state RUN.
  - i_valid in IDLE is ignored (never accepted).
- RUN:
  - o_ready = (fill < OUT_BYTES) and not o_valid-full.
  - Accepted beat at row-beat index b: lane k is selected iff col_start <= b*BUS_BYTES+k < col_start+col_width. Selected bytes are appended in ascending lane order at accumulator position fill; fill increases by the count.
  - Beat counter wraps to 0 after r_size-1 (next row).
  - Accumulator holds OUT_BYTES+BUS_BYTES-1 bytes.
- Output:
  - o_valid rises the cycle after the edge where fill >= OUT_BYTES.
  - On o_valid&i_ready: shift out OUT_BYTES, fill -= OUT_BYTES, o_keep=OUT_BYTES.
  - o_data, o_keep and o_last are held stable while o_valid & !i_ready.
- Simultaneous beat accept and output handshake in one cycle: shift first, then append; no byte lost or duplicated.
- i_last accepted in RUN: next state FLUSH. Remaining row beats are not expected, and the beat counter resets.
- FLUSH:
  - o_ready=0. Emit full words while fill >= OUT_BYTES.
  - Then emit one word with o_keep=fill, unused lanes zero, o_last=1.
  - If fill is exactly a multiple of OUT_BYTES, the last full word carries o_last=1 and no extra word is sent.
  - Frame with zero selected bytes (col_width=0 or col_start beyond row): exactly one word, o_keep=0, o_data=0, o_last=1.
  - After the o_last handshake: IDLE.
- Config error: extraction still runs; out-of-row bytes simply never match.
- Latency: beat-to-o_valid is 1 cycle when that beat completes a word. Throughput is 1 beat/cycle while i_ready=1 and output width >= column bytes per beat.

Test Plan:
- BUS_BYTES=16, r_size=1, col_start=0, col_width=9, 4 beats of 128'hff_ee_..._11_00, i_last on beat 4 -> word0 = {00..88}x3 then 00,11,22,33,44, keep=32, last=0; word1 = 55,66,77,88, keep=4, last=1.
- r_size=2, col_start=12, col_width=8, same data both beats, 4 rows -> bytes cc,dd,ee,ff,00,11,22,33 repeated 4x; one word, keep=32, last=1, no extra word.
- Scenario 1 with i_ready=0 for 10 cycles after first o_valid -> o_data/o_keep stable, o_ready=0 while fill>=32, full byte sequence intact after release.
- col_width=0, 3 beats -> single word, keep=0, data=0, last=1; col_start=10, col_width=10, r_size=1 -> o_cfg_err=1, bytes aa..ff only per row.
- i_rst pulsed mid-frame with fill=20 -> next cycle o_valid=0, o_busy=0. A new i_start frame then produces only new-frame bytes.
- Back-to-back beats with output handshake each cycle (col_width=16, r_size=1) -> one 32-byte word every 2 beats, no stalls, o_ready stays 1.
